servclone10_pll_ctrl: RTL and testbench

Lock/reset sequencer for the Cyclone 10 LP PLL in the servclone10 clock tree. It runs on the raw board reference clock, drives the PLL areset and synchronizes and supervises the PLL locked flag. It releases a system reset request only after a stable lock plus a stretch interval. On lock timeout or loss of lock it retries, and after a retry budget is exhausted it parks in FAIL.

---
 rtl/servclone10_pll_pkg.sv | 35 +++
 rtl/servclone10_pll_ctrl_if.sv | 45 ++++
 rtl/servclone10_sync2.sv | 30 +++
 rtl/servclone10_pll_ctrl.sv | 133 +++++++++++++
 tb/tb_servclone10_pll_ctrl.sv | 144 ++++++++++++++
 5 files changed

// File: rtl/servclone10_pll_pkg.sv
`default_nettype none
// ============================================================================
// Module      : servclone10_pll_pkg
// Description : Shared types and sizing helpers for the servclone10 PLL
//               lock/reset sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package servclone10_pll_pkg;

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STRETCH   = 3'd2,
        RUN       = 3'd3,
        FAIL      = 3'd4
    } pll_state_t;

    // Counter width: enough bits to reach (largest interval - 1), never zero.
    function automatic int cnt_width(input int rst_cycles,
                                     input int lock_timeout,
                                     input int stretch_cycles);
        int m;
        m = rst_cycles;
        if (lock_timeout > m)   m = lock_timeout;
        if (stretch_cycles > m) m = stretch_cycles;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

    // Retry counter width; a zero retry budget still needs a 1-bit port.
    function automatic int retry_width(input int max_retries);
        return (max_retries > 0) ? $clog2(max_retries + 1) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/servclone10_pll_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : servclone10_pll_ctrl_if
// Description : Control/status bundle between the PLL sequencer and its
//               environment (restart request, raw lock, reset outputs).
// Revision    : 1.0 - initial release
// ============================================================================
interface servclone10_pll_ctrl_if
    import servclone10_pll_pkg::*;
#(
    parameter int MAX_RETRIES = 3
);
    localparam int RETRY_W = retry_width(MAX_RETRIES);

    logic               i_restart;
    logic               i_pll_locked;
    logic               o_pll_areset;
    logic               o_rst;
    logic               o_ready;
    logic               o_fail;
    logic [RETRY_W-1:0] o_retries;

    // Environment side: drives requests, observes sequencer status.
    modport master (
        output i_restart,
        output i_pll_locked,
        input  o_pll_areset,
        input  o_rst,
        input  o_ready,
        input  o_fail,
        input  o_retries
    );

    // Sequencer side.
    modport slave (
        input  i_restart,
        input  i_pll_locked,
        output o_pll_areset,
        output o_rst,
        output o_ready,
        output o_fail,
        output o_retries
    );
endinterface
`default_nettype wire

// File: rtl/servclone10_sync2.sv
`default_nettype none
// ============================================================================
// Module      : servclone10_sync2
// Description : Two-flop synchronizer with asynchronous active-low reset.
//               Output is 0 while in reset.
// Revision    : 1.0 - initial release
// ============================================================================
module servclone10_sync2 (
    input  wire logic i_clk,
    input  wire logic i_rst_n,
    input  wire logic i_d,
    output logic      o_q
);
    logic meta_q;
    logic sync_q;

    // Two register stages to resolve metastability of the asynchronous input.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= i_d;
            sync_q <= meta_q;
        end
    end

    assign o_q = sync_q;
endmodule
`default_nettype wire

// File: rtl/servclone10_pll_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : servclone10_pll_ctrl
// Description : Cyclone 10 LP PLL lock/reset sequencer. Pulses PLL areset,
//               supervises the synchronized lock flag, stretches the system
//               reset after lock, retries on timeout / lock loss and parks
//               in FAIL once the retry budget is spent.
// Revision    : 1.0 - initial release
// ============================================================================
module servclone10_pll_ctrl
    import servclone10_pll_pkg::*;
#(
    parameter int RST_CYCLES     = 16,
    parameter int LOCK_TIMEOUT   = 12000,
    parameter int STRETCH_CYCLES = 1024,
    parameter int MAX_RETRIES    = 3
) (
    input  wire logic             i_clk,
    input  wire logic             i_rst_n,
    servclone10_pll_ctrl_if.slave bus
);
    localparam int CNT_W   = cnt_width(RST_CYCLES, LOCK_TIMEOUT, STRETCH_CYCLES);
    localparam int RETRY_W = retry_width(MAX_RETRIES);

    // Each interval ends on the cycle its counter reaches (length - 1).
    localparam logic [CNT_W-1:0]   c_rst_last     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   c_timeout_last = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   c_stretch_last = CNT_W'(STRETCH_CYCLES - 1);
    localparam logic [CNT_W-1:0]   c_cnt_max      = {CNT_W{1'b1}};
    localparam logic [RETRY_W-1:0] c_max_retries  = RETRY_W'(MAX_RETRIES);

    logic lock_s;

    pll_state_t         state_q,   state_d;
    logic [CNT_W-1:0]   cnt_q,     cnt_d;
    logic [RETRY_W-1:0] retries_q, retries_d;
    logic               areset_q,  areset_d;
    logic               rst_q,     rst_d;
    logic               ready_q,   ready_d;
    logic               fail_q,    fail_d;
    logic               retry;

    servclone10_sync2 u_lock_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (bus.i_pll_locked),
        .o_q     (lock_s)
    );

    // Next-state, shared cycle counter, retry bookkeeping and the outputs
    // implied by the state being entered.
    always_comb begin
        state_d   = state_q;
        retries_d = retries_q;
        retry     = 1'b0;
        cnt_d     = (cnt_q == c_cnt_max) ? cnt_q : cnt_q + CNT_W'(1);

        case (state_q)
            PLL_RST: begin
                // Lock is deliberately ignored: the full areset pulse always runs.
                if (cnt_q == c_rst_last) state_d = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (lock_s)                        state_d = STRETCH;
                else if (cnt_q == c_timeout_last)  retry   = 1'b1;
            end
            STRETCH: begin
                if (!lock_s)                       retry   = 1'b1;
                else if (cnt_q == c_stretch_last)  state_d = RUN;
            end
            RUN: begin
                if (!lock_s) retry = 1'b1;
            end
            FAIL: begin
                state_d = FAIL;
            end
            default: begin
                state_d = PLL_RST;
            end
        endcase

        if (retry) begin
            if (retries_q == c_max_retries) begin
                state_d = FAIL;
            end else begin
                retries_d = retries_q + RETRY_W'(1);
                state_d   = PLL_RST;
            end
        end

        // Restart overrides every other decision made this cycle.
        if (bus.i_restart) begin
            state_d   = PLL_RST;
            retries_d = '0;
        end

        // Counter reloads on each state entry, including PLL_RST re-entry.
        if ((state_d != state_q) || bus.i_restart) cnt_d = '0;

        areset_d = (state_d == PLL_RST) || (state_d == FAIL);
        rst_d    = (state_d != RUN);
        ready_d  = (state_d == RUN);
        fail_d   = (state_d == FAIL);
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= PLL_RST;
            cnt_q     <= '0;
            retries_q <= '0;
            areset_q  <= 1'b1;
            rst_q     <= 1'b1;
            ready_q   <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retries_q <= retries_d;
            areset_q  <= areset_d;
            rst_q     <= rst_d;
            ready_q   <= ready_d;
            fail_q    <= fail_d;
        end
    end

    assign bus.o_pll_areset = areset_q;
    assign bus.o_rst        = rst_q;
    assign bus.o_ready      = ready_q;
    assign bus.o_fail       = fail_q;
    assign bus.o_retries    = retries_q;
endmodule
`default_nettype wire

// File: tb/tb_servclone10_pll_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_servclone10_pll_ctrl
// Description : Table-driven self-checking bench for the PLL sequencer with
//               RST_CYCLES=4, LOCK_TIMEOUT=20, STRETCH_CYCLES=8, MAX_RETRIES=2.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_servclone10_pll_ctrl;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    servclone10_pll_ctrl_if #(.MAX_RETRIES(2)) bus ();

    servclone10_pll_ctrl #(
        .RST_CYCLES     (4),
        .LOCK_TIMEOUT   (20),
        .STRETCH_CYCLES (8),
        .MAX_RETRIES    (2)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    // One row: optional async reset pulse first, then n clock edges with the
    // given inputs; after every edge outputs must equal exp
    // (exp = {areset, rst, ready, fail, retries[1:0]}).
    typedef struct {
        string      name;
        bit         arst;
        int         n;
        bit         restart;
        bit         lock;
        logic [5:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(input string nm, input bit arst, input int n,
                                input bit rs, input bit lk, input bit ar,
                                input bit rst, input bit rdy, input bit fl,
                                input int ret);
        vec_t v;
        v.name    = nm;
        v.arst    = arst;
        v.n       = n;
        v.restart = rs;
        v.lock    = lk;
        v.exp     = {ar, rst, rdy, fl, 2'(ret)};
        return v;
    endfunction

    task automatic check(input string nm, input int idx, input logic [5:0] exp);
        logic [5:0] act;
        act = {bus.o_pll_areset, bus.o_rst, bus.o_ready, bus.o_fail, bus.o_retries};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: areset/rst/ready/fail/retries got %b expected %b",
                     nm, idx, act, exp);
        end
    endtask

    initial begin
        bus.i_restart    = 1'b0;
        bus.i_pll_locked = 1'b0;
        repeat (3) @(negedge clk);

        //                 name           arst n  rs lk  ar rst rdy fl ret
        // Clean bring-up: lock raised 3 cycles after areset falls.
        vecs.push_back(mk("boot_areset",   1, 3,  0, 0,  1, 1, 0, 0, 0));
        vecs.push_back(mk("boot_wait",     0, 3,  0, 0,  0, 1, 0, 0, 0));
        vecs.push_back(mk("boot_stretch",  0, 10, 0, 1,  0, 1, 0, 0, 0));
        vecs.push_back(mk("boot_run",      0, 3,  0, 1,  0, 0, 1, 0, 0));
        // One-cycle lock drop in RUN: retry seen on the third edge.
        vecs.push_back(mk("run_drop",      0, 1,  0, 0,  0, 0, 1, 0, 0));
        vecs.push_back(mk("run_drop_sync", 0, 1,  0, 1,  0, 0, 1, 0, 0));
        vecs.push_back(mk("run_retry",     0, 1,  0, 1,  1, 1, 0, 0, 1));
        vecs.push_back(mk("rec_areset",    0, 3,  0, 1,  1, 1, 0, 0, 1));
        vecs.push_back(mk("rec_wait",      0, 1,  0, 1,  0, 1, 0, 0, 1));
        vecs.push_back(mk("rec_stretch",   0, 8,  0, 1,  0, 1, 0, 0, 1));
        vecs.push_back(mk("rec_run",       0, 2,  0, 1,  0, 0, 1, 0, 1));
        // Restart coincides with lock loss seen in RUN.
        vecs.push_back(mk("rs_drop",       0, 2,  0, 0,  0, 0, 1, 0, 1));
        vecs.push_back(mk("rs_prio",       0, 1,  1, 0,  1, 1, 0, 0, 0));
        // Three lock timeouts then FAIL.
        vecs.push_back(mk("to0_areset",    0, 3,  0, 0,  1, 1, 0, 0, 0));
        vecs.push_back(mk("to0_wait",      0, 20, 0, 0,  0, 1, 0, 0, 0));
        vecs.push_back(mk("to1_areset",    0, 4,  0, 0,  1, 1, 0, 0, 1));
        vecs.push_back(mk("to1_wait",      0, 20, 0, 0,  0, 1, 0, 0, 1));
        vecs.push_back(mk("to2_areset",    0, 4,  0, 0,  1, 1, 0, 0, 2));
        vecs.push_back(mk("to2_wait",      0, 20, 0, 0,  0, 1, 0, 0, 2));
        vecs.push_back(mk("to_fail",       0, 1,  0, 0,  1, 1, 0, 1, 2));
        vecs.push_back(mk("fail_lock_ign", 0, 6,  0, 1,  1, 1, 0, 1, 2));
        vecs.push_back(mk("fail_restart",  0, 1,  1, 1,  1, 1, 0, 0, 0));
        // Glitch in STRETCH at stretch cycle 5.
        vecs.push_back(mk("gl_areset",     0, 3,  0, 1,  1, 1, 0, 0, 0));
        vecs.push_back(mk("gl_wait",       0, 1,  0, 1,  0, 1, 0, 0, 0));
        vecs.push_back(mk("gl_stretch",    0, 4,  0, 1,  0, 1, 0, 0, 0));
        vecs.push_back(mk("gl_drop",       0, 1,  0, 0,  0, 1, 0, 0, 0));
        vecs.push_back(mk("gl_drop_sync",  0, 1,  0, 1,  0, 1, 0, 0, 0));
        vecs.push_back(mk("gl_retry",      0, 1,  0, 1,  1, 1, 0, 0, 1));
        vecs.push_back(mk("gl2_areset",    0, 3,  0, 1,  1, 1, 0, 0, 1));
        vecs.push_back(mk("gl2_wait",      0, 1,  0, 1,  0, 1, 0, 0, 1));
        vecs.push_back(mk("gl2_stretch",   0, 8,  0, 1,  0, 1, 0, 0, 1));
        vecs.push_back(mk("gl2_run",       0, 2,  0, 1,  0, 0, 1, 0, 1));
        // Second lock loss, then async reset in the middle of STRETCH.
        vecs.push_back(mk("ar_drop",       0, 1,  0, 0,  0, 0, 1, 0, 1));
        vecs.push_back(mk("ar_drop_sync",  0, 1,  0, 1,  0, 0, 1, 0, 1));
        vecs.push_back(mk("ar_retry",      0, 1,  0, 1,  1, 1, 0, 0, 2));
        vecs.push_back(mk("ar_areset",     0, 3,  0, 1,  1, 1, 0, 0, 2));
        vecs.push_back(mk("ar_wait_str",   0, 4,  0, 1,  0, 1, 0, 0, 2));
        vecs.push_back(mk("post_areset",   1, 3,  0, 1,  1, 1, 0, 0, 0));
        vecs.push_back(mk("post_wait",     0, 1,  0, 1,  0, 1, 0, 0, 0));
        vecs.push_back(mk("post_stretch",  0, 8,  0, 1,  0, 1, 0, 0, 0));
        vecs.push_back(mk("post_run",      0, 2,  0, 1,  0, 0, 1, 0, 0));

        foreach (vecs[i]) begin
            if (vecs[i].arst) begin
                // Reset pulse entirely inside the low clock phase: outputs
                // must take reset values with no clock edge in between.
                #1 rst_n = 1'b0;
                #1 check("async_reset", i, 6'b110000);
                #1 rst_n = 1'b1;
            end
            for (int k = 0; k < vecs[i].n; k++) begin
                bus.i_restart    = vecs[i].restart;
                bus.i_pll_locked = vecs[i].lock;
                @(posedge clk);
                @(negedge clk);
                check(vecs[i].name, k, vecs[i].exp);
            end
        end

        bus.i_restart = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
